// File: rtl/fpas_sched_pkg.sv
// fpas_sched_pkg: shared types, constants and round-robin pick helper for the fpas scheduler.
package fpas_sched_pkg;

    localparam int FP_W    = 32;
    localparam int FP_SIGN = 31;

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } pick_t;

    // Scans ptr, ptr+1, ... (mod n) and returns the first set valid bit; n is 1..16.
    // Descending k so the lowest offset from ptr is the last (winning) assignment.
    function automatic pick_t rr_pick(input logic [15:0] valid, input logic [3:0] ptr, input int n);
        pick_t r;
        int    j;
        r = '0;
        for (int k = 15; k >= 0; k--) begin
            j = (int'(ptr) + k) % n;
            if (k < n && valid[j]) r = '{1'b1, 4'(j)};
        end
        return r;
    endfunction

endpackage

// File: rtl/fpas.sv
// fpas: combinational IEEE-754 single-precision adder, round-to-nearest-even.
//   a, b [32] operands; s [32] sum. NaN results are the canonical quiet NaN.
module fpas (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] s
);

    logic [31:0] x, y;
    logic [7:0]  ex, ey, d;
    logic [23:0] mx, my;
    logic [49:0] ysh;
    logic [26:0] xe, ye, n;
    logic [27:0] sm;
    logic [4:0]  lz;
    logic [8:0]  sh, e;
    logic        up;
    logic [30:0] mag;
    logic        a_nan, b_nan, a_inf, b_inf;

    always_comb begin
        // x always holds the larger magnitude, so the result sign is x's unless the sum is zero
        x     = (b[30:0] > a[30:0]) ? b : a;
        y     = (b[30:0] > a[30:0]) ? a : b;
        ex    = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        ey    = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        mx    = {x[30:23] != 8'd0, x[22:0]};
        my    = {y[30:23] != 8'd0, y[22:0]};
        d     = ex - ey;
        ysh   = {my, 26'd0} >> d;
        // three extra bits: guard, round, sticky
        xe    = {mx, 3'b000};
        ye    = {ysh[49:24], |ysh[23:0]};
        sm    = (x[31] ^ y[31]) ? {1'b0, xe} - {1'b0, ye} : {1'b0, xe} + {1'b0, ye};
        lz    = 5'd0;
        for (int i = 0; i < 27; i++) if (sm[i]) lz = 5'(26 - i);
        // left shift limited so the exponent never drops below 1 (denormal results)
        sh    = (9'(lz) > 9'(ex) - 9'd1) ? 9'(ex) - 9'd1 : 9'(lz);
        n     = sm[27] ? {sm[27:2], |sm[1:0]} : sm[26:0] << sh;
        e     = sm[27] ? 9'(ex) + 9'd1 : 9'(ex) - sh;
        up    = n[2] & (n[1] | n[0] | n[3]);
        // rounding carry ripples into the exponent field, producing inf on overflow
        mag   = {(n[26] ? e[7:0] : 8'd0), n[25:3]} + 31'(up);
        s     = (e >= 9'd255) ? {x[31], 31'h7F800000} : {x[31], mag};
        if (sm == 28'd0) s = {x[31] & y[31], 31'd0};
        a_nan = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
        b_nan = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
        a_inf = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
        b_inf = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
        if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) s = 32'h7FC00000;
        else if (a_inf) s = a;
        else if (b_inf) s = b;
    end

endmodule

// File: rtl/rr_pick_core.sv
// rr_pick_core: combinational round-robin priority pick.
//   valid [N]  request bits; ptr [IW] highest-priority index
//   found      any valid bit set; idx [IW] winning index
module rr_pick_core
    import fpas_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] idx
);

    pick_t p;

    always_comb begin
        p     = rr_pick(16'(valid), 4'(ptr), N);
        found = p.found;
        idx   = IW'(p.idx);
    end

endmodule

// File: rtl/fpas_rr_sched.sv
// fpas_rr_sched: round-robin scheduler sharing one fpas adder among NREQ requesters.
//   clk, rst_n (async, active-low)
//   req_valid/req_ready [NREQ], req_a/req_b [32*NREQ]: per-requester operand handshake
//   rsp_valid/rsp_ready, rsp_id [IDW], rsp_sum [32]: single response channel
//   busy: high whenever not IDLE
//   FPAS_SUB_EN: adds req_sub [NREQ] (subtract request) and rsp_sub (echoed op bit)
module fpas_rr_sched
    import fpas_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [FP_W*NREQ-1:0] req_a,
    input  logic [FP_W*NREQ-1:0] req_b,
`ifdef FPAS_SUB_EN
    input  logic [NREQ-1:0]      req_sub,
    output logic                 rsp_sub,
`endif
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [IDW-1:0]       rsp_id,
    output logic [FP_W-1:0]      rsp_sum,
    output logic                 busy
);

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d, op_id_q, op_id_d, rsp_id_q, rsp_id_d;
    logic [FP_W-1:0] op_a_q, op_a_d, op_b_q, op_b_d, rsp_sum_q, rsp_sum_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic            found;
    logic [IDW-1:0]  g;
    logic [FP_W-1:0] fb, s;

    rr_pick_core #(.N(NREQ), .IW(IDW)) u_pick (
        .valid(req_valid),
        .ptr  (rr_ptr_q),
        .found(found),
        .idx  (g)
    );

    fpas u_fpas (
        .a(op_a_q),
        .b(fb),
        .s(s)
    );

`ifdef FPAS_SUB_EN
    logic op_sub_q, op_sub_d, rsp_sub_q, rsp_sub_d;
    always_comb begin
        op_sub_d  = (state_q == IDLE && found) ? req_sub[g] : op_sub_q;
        rsp_sub_d = (state_q == EXEC) ? op_sub_q : rsp_sub_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_sub_q  <= 1'b0;
            rsp_sub_q <= 1'b0;
        end else begin
            op_sub_q  <= op_sub_d;
            rsp_sub_q <= rsp_sub_d;
        end
    end
    // flipping b's sign turns the shared adder into a subtractor
    assign fb      = {op_b_q[FP_SIGN] ^ op_sub_q, op_b_q[FP_SIGN-1:0]};
    assign rsp_sub = rsp_sub_q;
`else
    assign fb = op_b_q;
`endif

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        op_a_d      = op_a_q;
        op_b_d      = op_b_q;
        op_id_d     = op_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_id_d    = rsp_id_q;
        rsp_valid_d = rsp_valid_q;
        req_ready   = '0;
        case (state_q)
            IDLE: if (found) begin
                req_ready[g] = 1'b1;
                op_a_d       = req_a[FP_W*g +: FP_W];
                op_b_d       = req_b[FP_W*g +: FP_W];
                op_id_d      = g;
                rr_ptr_d     = (int'(g) == NREQ - 1) ? '0 : g + IDW'(1);
                state_d      = EXEC;
            end
            EXEC: begin
                rsp_sum_d   = s;
                rsp_id_d    = op_id_q;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: if (rsp_ready) begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            op_id_q     <= '0;
            rsp_sum_q   <= '0;
            rsp_id_q    <= '0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            op_id_q     <= op_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_id_q    <= rsp_id_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);

endmodule
